// File: rtl/csr_pkg.sv
// Shared CSR constants for the M-mode trap path: addresses, cause codes,
// mstatus bit positions, Zicsr write-mode encodings and trap FSM states.
package csr_pkg;

  // CSR addresses
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  // Synchronous exception cause codes
  localparam int unsigned CAUSE_ILLEGAL = 2;
  localparam int unsigned CAUSE_LFAULT  = 5;
  localparam int unsigned CAUSE_SFAULT  = 7;
  localparam int unsigned CAUSE_ECALL_M = 11;

  // mstatus bit positions
  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;
  localparam int MPP_LO   = 11;
  localparam int MPP_HI   = 12;

  // CSR write-port mode encodings
  localparam logic [1:0] WSC_NONE  = 2'b00;
  localparam logic [1:0] WSC_WRITE = 2'b01;
  localparam logic [1:0] WSC_SET   = 2'b10;
  localparam logic [1:0] WSC_CLEAR = 2'b11;

  // Trap-entry sequencer states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    W_MEPC   = 2'd1,
    W_MCAUSE = 2'd2
  } trap_state_e;

endpackage

// File: rtl/trap_priority_encoder.sv
// Picks the highest-priority trap source in the WB stage and produces the
// cause, return PC and mtval that go with it. Purely combinational.
module trap_priority_encoder
  import csr_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] IRQ_CAUSE = XLEN'(32'h8000000B)
) (
  input  logic            illegal_inst_i,
  input  logic            ecall_m_i,
  input  logic            l_fault_i,
  input  logic            s_fault_i,
  input  logic            interrupt_i,
  input  logic            mret_i,
  input  logic            mie_i,
  input  logic [31:0]     inst_wb_i,
  input  logic [XLEN-1:0] addr_wb_i,
  input  logic [XLEN-1:0] epc_cur_i,
  input  logic [XLEN-1:0] epc_next_i,
  output logic            take_o,
  output logic [XLEN-1:0] cause_o,
  output logic [XLEN-1:0] epc_o,
  output logic [XLEN-1:0] mtval_o
);

  // Fixed-priority select: exceptions first, interrupt only when nothing else
  // (including mret) claims the instruction and MIE is set.
  always_comb begin
    // NOTE: every output gets a default up front so no path leaves one unassigned (no latch).
    take_o  = 1'b0;
    cause_o = '0;
    epc_o   = epc_cur_i;
    mtval_o = '0;
    if (illegal_inst_i) begin
      take_o  = 1'b1;
      cause_o = XLEN'(CAUSE_ILLEGAL);
      mtval_o = XLEN'(inst_wb_i);
    end else if (ecall_m_i) begin
      take_o  = 1'b1;
      cause_o = XLEN'(CAUSE_ECALL_M);
    end else if (l_fault_i) begin
      take_o  = 1'b1;
      cause_o = XLEN'(CAUSE_LFAULT);
      mtval_o = addr_wb_i;
    end else if (s_fault_i) begin
      take_o  = 1'b1;
      cause_o = XLEN'(CAUSE_SFAULT);
      mtval_o = addr_wb_i;
    end else if (interrupt_i && mie_i && !mret_i) begin
      take_o  = 1'b1;
      cause_o = IRQ_CAUSE;
      epc_o   = epc_next_i;
    end
  end

endmodule

// File: rtl/exception_unit.sv
// M-mode trap controller in WB. Owns the single CSR write port: sequences
// trap entry (mstatus+mtval, mepc, mcause), handles mret, and otherwise
// passes Zicsr writes straight through. Redirects fetch and flushes on traps.
module exception_unit
  import csr_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] IRQ_CAUSE = XLEN'(32'h8000000B)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_wb,
  input  logic            illegal_inst,
  input  logic            ecall_m,
  input  logic            l_fault,
  input  logic            s_fault,
  input  logic            interrupt,
  input  logic            mret,
  input  logic [31:0]     inst_wb,
  input  logic [XLEN-1:0] addr_wb,
  input  logic [XLEN-1:0] epc_cur,
  input  logic [XLEN-1:0] epc_next,
  input  logic            csr_rw_in,
  input  logic [1:0]      csr_wsc_in,
  input  logic [11:0]     csr_waddr_in,
  input  logic [XLEN-1:0] csr_wdata_in,
  input  logic [XLEN-1:0] mstatus,
  input  logic [XLEN-1:0] mepc,
  input  logic [XLEN-1:0] mtvec,
  output logic            csr_w,
  output logic [11:0]     csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  output logic [1:0]      csr_wsc_mode,
  output logic            mtval_data_in,
  output logic [XLEN-1:0] mtval_data,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic            busy
);

  trap_state_e     state_q, state_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] cause_q, cause_d;

  logic            trap_take;
  logic [XLEN-1:0] trap_cause, trap_epc, trap_mtval;
  logic [XLEN-1:0] mstatus_trap, mstatus_mret;

  trap_priority_encoder #(
    .XLEN      (XLEN),
    .IRQ_CAUSE (IRQ_CAUSE)
  ) u_prio (
    .illegal_inst_i (illegal_inst),
    .ecall_m_i      (ecall_m),
    .l_fault_i      (l_fault),
    .s_fault_i      (s_fault),
    .interrupt_i    (interrupt),
    .mret_i         (mret),
    .mie_i          (mstatus[MIE_BIT]),
    .inst_wb_i      (inst_wb),
    .addr_wb_i      (addr_wb),
    .epc_cur_i      (epc_cur),
    .epc_next_i     (epc_next),
    .take_o         (trap_take),
    .cause_o        (trap_cause),
    .epc_o          (trap_epc),
    .mtval_o        (trap_mtval)
  );

  // New mstatus images for trap entry and for mret.
  always_comb begin
    mstatus_trap                  = mstatus;
    mstatus_trap[MPP_HI:MPP_LO]   = 2'b11;
    mstatus_trap[MPIE_BIT]        = mstatus[MIE_BIT];
    mstatus_trap[MIE_BIT]         = 1'b0;

    mstatus_mret                  = mstatus;
    mstatus_mret[MPP_HI:MPP_LO]   = 2'b11;
    mstatus_mret[MPIE_BIT]        = 1'b1;
    mstatus_mret[MIE_BIT]         = mstatus[MPIE_BIT];
  end

  // Output decode and next state. Outputs are held at zero while rst is high.
  always_comb begin
    state_d       = state_q;
    epc_d         = epc_q;
    cause_d       = cause_q;
    csr_w         = 1'b0;
    csr_waddr     = '0;
    csr_wdata     = '0;
    csr_wsc_mode  = WSC_NONE;
    mtval_data_in = 1'b0;
    mtval_data    = '0;
    redirect      = 1'b0;
    redirect_pc   = '0;
    flush         = 1'b0;
    busy          = 1'b0;

    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (valid_wb) begin
            if (trap_take) begin
              csr_w         = 1'b1;
              csr_waddr     = CSR_MSTATUS;
              csr_wdata     = mstatus_trap;
              csr_wsc_mode  = WSC_WRITE;
              mtval_data_in = 1'b1;
              mtval_data    = trap_mtval;
              redirect      = 1'b1;
              redirect_pc   = mtvec & ~XLEN'(3);
              flush         = 1'b1;
              epc_d         = trap_epc;
              cause_d       = trap_cause;
              state_d       = W_MEPC;
            end else if (mret) begin
              csr_w         = 1'b1;
              csr_waddr     = CSR_MSTATUS;
              csr_wdata     = mstatus_mret;
              csr_wsc_mode  = WSC_WRITE;
              redirect      = 1'b1;
              redirect_pc   = mepc;
              flush         = 1'b1;
            end else begin
              csr_w         = csr_rw_in;
              csr_waddr     = csr_waddr_in;
              csr_wdata     = csr_wdata_in;
              csr_wsc_mode  = csr_wsc_in;
            end
          end
        end
        W_MEPC: begin
          busy         = 1'b1;
          csr_w        = 1'b1;
          csr_waddr    = CSR_MEPC;
          csr_wdata    = epc_q;
          csr_wsc_mode = WSC_WRITE;
          state_d      = W_MCAUSE;
        end
        W_MCAUSE: begin
          busy         = 1'b1;
          csr_w        = 1'b1;
          csr_waddr    = CSR_MCAUSE;
          csr_wdata    = cause_q;
          csr_wsc_mode = WSC_WRITE;
          state_d      = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and latched trap info; rst aborts any sequence immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      epc_q   <= '0;
      cause_q <= '0;
    end else begin
      // NOTE: registers use non-blocking assignment so all flops update together at the edge.
      state_q <= state_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
    end
  end

endmodule

// File: tb/tb_exception_unit.sv
// Bench for exception_unit: directed scenarios plus randomized traffic, all
// compared cycle by cycle against a queue-based model of pending CSR writes.
module tb_exception_unit;

  localparam logic [31:0] IRQ = 32'h8000000B;

  logic        clk, rst;
  logic        valid_wb, illegal_inst, ecall_m, l_fault, s_fault, interrupt, mret;
  logic [31:0] inst_wb, addr_wb, epc_cur, epc_next;
  logic        csr_rw_in;
  logic [1:0]  csr_wsc_in;
  logic [11:0] csr_waddr_in;
  logic [31:0] csr_wdata_in, mstatus, mepc, mtvec;
  logic        csr_w, mtval_data_in, redirect, flush, busy;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata, mtval_data, redirect_pc;
  logic [1:0]  csr_wsc_mode;

  exception_unit dut (
    .clk(clk), .rst(rst), .valid_wb(valid_wb), .illegal_inst(illegal_inst),
    .ecall_m(ecall_m), .l_fault(l_fault), .s_fault(s_fault),
    .interrupt(interrupt), .mret(mret), .inst_wb(inst_wb), .addr_wb(addr_wb),
    .epc_cur(epc_cur), .epc_next(epc_next), .csr_rw_in(csr_rw_in),
    .csr_wsc_in(csr_wsc_in), .csr_waddr_in(csr_waddr_in),
    .csr_wdata_in(csr_wdata_in), .mstatus(mstatus), .mepc(mepc), .mtvec(mtvec),
    .csr_w(csr_w), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .csr_wsc_mode(csr_wsc_mode), .mtval_data_in(mtval_data_in),
    .mtval_data(mtval_data), .redirect(redirect), .redirect_pc(redirect_pc),
    .flush(flush), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Model: trap entry queues the two follow-up CSR writes; while that queue
  // is non-empty the unit is busy and drives its head.
  typedef struct { logic [11:0] a; logic [31:0] d; } wr_t;
  wr_t pend[$];

  logic        e_w, e_mtin, e_redir, e_flush, e_busy, e_trap;
  logic [11:0] e_addr;
  logic [31:0] e_data, e_mtval, e_pc, q_epc, q_cause;
  logic [1:0]  e_mode;

  task automatic model_eval();
    logic exc;
    e_w = 0; e_mtin = 0; e_redir = 0; e_flush = 0; e_busy = 0; e_trap = 0;
    e_addr = 0; e_data = 0; e_mtval = 0; e_pc = 0; e_mode = 0;
    exc = illegal_inst | ecall_m | l_fault | s_fault;
    if (rst) begin
      // everything stays zero
    end else if (pend.size() > 0) begin
      e_busy = 1; e_w = 1; e_mode = 2'b01;
      e_addr = pend[0].a; e_data = pend[0].d;
    end else if (valid_wb && (exc || (interrupt && mstatus[3] && !mret))) begin
      e_trap = 1;
      q_epc  = exc ? epc_cur : epc_next;
      if (illegal_inst)      begin q_cause = 2;  e_mtval = inst_wb; end
      else if (ecall_m)      begin q_cause = 11; e_mtval = 0;       end
      else if (l_fault)      begin q_cause = 5;  e_mtval = addr_wb; end
      else if (s_fault)      begin q_cause = 7;  e_mtval = addr_wb; end
      else                   begin q_cause = IRQ; e_mtval = 0;      end
      e_w = 1; e_addr = 12'h300; e_mode = 2'b01; e_mtin = 1;
      e_data = (mstatus & ~32'h0000_1888) | 32'h0000_1800 | (mstatus[3] ? 32'h80 : 32'h0);
      e_redir = 1; e_flush = 1; e_pc = {mtvec[31:2], 2'b00};
    end else if (valid_wb && mret) begin
      e_w = 1; e_addr = 12'h300; e_mode = 2'b01;
      e_data = (mstatus & ~32'h0000_1888) | 32'h0000_1880 | (mstatus[7] ? 32'h8 : 32'h0);
      e_redir = 1; e_flush = 1; e_pc = mepc;
    end else if (valid_wb) begin
      e_w = csr_rw_in; e_addr = csr_waddr_in; e_data = csr_wdata_in; e_mode = csr_wsc_in;
    end
  endtask

  task automatic model_check();
    model_eval();
    check("csr_w", csr_w, e_w);
    if (e_w) begin
      check("csr_waddr", csr_waddr, e_addr);
      check("csr_wdata", csr_wdata, e_data);
      check("csr_wsc_mode", csr_wsc_mode, e_mode);
    end
    check("mtval_data_in", mtval_data_in, e_mtin);
    if (e_mtin) check("mtval_data", mtval_data, e_mtval);
    check("redirect", redirect, e_redir);
    if (e_redir) check("redirect_pc", redirect_pc, e_pc);
    check("flush", flush, e_flush);
    check("busy", busy, e_busy);
  endtask

  task automatic model_update();
    wr_t w;
    if (rst) pend.delete();
    else if (pend.size() > 0) void'(pend.pop_front());
    else if (e_trap) begin
      w.a = 12'h341; w.d = q_epc;   pend.push_back(w);
      w.a = 12'h342; w.d = q_cause; pend.push_back(w);
    end
  endtask

  // Inputs are driven right after a negedge; outputs sampled 1 time unit later.
  task automatic cyc_begin();
    #1;
    model_check();
  endtask

  task automatic cyc_end();
    model_update();
    @(negedge clk);
  endtask

  task automatic cycle();
    cyc_begin();
    cyc_end();
  endtask

  task automatic quiet();
    valid_wb = 0; illegal_inst = 0; ecall_m = 0; l_fault = 0; s_fault = 0;
    interrupt = 0; mret = 0; csr_rw_in = 0; csr_wsc_in = 0;
    csr_waddr_in = 0; csr_wdata_in = 0;
  endtask

  initial begin
    rst = 1; quiet();
    inst_wb = 0; addr_wb = 0; epc_cur = 0; epc_next = 0;
    mstatus = 0; mepc = 0; mtvec = 0;
    @(negedge clk);

    // Reset: every output zero
    valid_wb = 1; illegal_inst = 1;
    cyc_begin();
    check("rst_csr_w", csr_w, 0);       check("rst_waddr", csr_waddr, 0);
    check("rst_wdata", csr_wdata, 0);   check("rst_mode", csr_wsc_mode, 0);
    check("rst_mtval_in", mtval_data_in, 0); check("rst_mtval", mtval_data, 0);
    check("rst_redirect", redirect, 0); check("rst_pc", redirect_pc, 0);
    check("rst_flush", flush, 0);       check("rst_busy", busy, 0);
    cyc_end();
    rst = 0; quiet();
    cycle();

    // Illegal instruction
    valid_wb = 1; illegal_inst = 1; epc_cur = 32'h100; inst_wb = 32'hFFFF_FFFF;
    mtvec = 32'h200; mstatus = 32'h88;
    cyc_begin();
    check("ill_redirect_pc", redirect_pc, 32'h200);
    check("ill_flush", flush, 1);
    check("ill_mstatus", csr_wdata, 32'h1880);
    check("ill_mtval", mtval_data, 32'hFFFF_FFFF);
    check("ill_busy0", busy, 0);
    cyc_end();
    quiet();
    cyc_begin(); check("ill_mepc", csr_wdata, 32'h100); check("ill_mepc_a", csr_waddr, 12'h341); check("ill_busy1", busy, 1); cyc_end();
    cyc_begin(); check("ill_mcause", csr_wdata, 2); check("ill_mcause_a", csr_waddr, 12'h342); check("ill_busy2", busy, 1); cyc_end();
    cyc_begin(); check("ill_busy3", busy, 0); cyc_end();

    // Interrupt, MIE = 1
    valid_wb = 1; interrupt = 1; mstatus = 32'h8; epc_next = 32'h104; epc_cur = 32'h100;
    cyc_begin(); check("irq_redirect", redirect, 1); check("irq_mtval", mtval_data, 0); cyc_end();
    quiet();
    cyc_begin(); check("irq_mepc", csr_wdata, 32'h104); cyc_end();
    cyc_begin(); check("irq_mcause", csr_wdata, IRQ); cyc_end();

    // Interrupt, MIE = 0
    valid_wb = 1; interrupt = 1; mstatus = 32'h0;
    cyc_begin(); check("irq_off_redirect", redirect, 0); check("irq_off_csr_w", csr_w, 0); cyc_end();
    quiet();

    // mret
    valid_wb = 1; mret = 1; mstatus = 32'h1880; mepc = 32'h104;
    cyc_begin(); check("mret_pc", redirect_pc, 32'h104); check("mret_mstatus", csr_wdata, 32'h1888); cyc_end();
    quiet();
    cyc_begin(); check("mret_idle_busy", busy, 0); check("mret_idle_w", csr_w, 0); cyc_end();

    // Zicsr csrrs pass-through
    valid_wb = 1; csr_rw_in = 1; csr_waddr_in = 12'h305; csr_wdata_in = 32'h10; csr_wsc_in = 2'b10;
    cyc_begin();
    check("zicsr_w", csr_w, 1); check("zicsr_a", csr_waddr, 12'h305);
    check("zicsr_d", csr_wdata, 32'h10); check("zicsr_m", csr_wsc_mode, 2'b10);
    cyc_end();
    // Same request with load fault: suppressed, trap instead
    l_fault = 1; addr_wb = 32'h8000;
    cyc_begin(); check("lf_addr", csr_waddr, 12'h300); check("lf_mtval", mtval_data, 32'h8000); cyc_end();
    quiet();
    cycle();
    cyc_begin(); check("lf_mcause", csr_wdata, 5); cyc_end();

    // illegal + ecall + interrupt together
    valid_wb = 1; illegal_inst = 1; ecall_m = 1; interrupt = 1; mstatus = 32'h8;
    cycle();
    quiet();
    cycle();
    cyc_begin(); check("prio_mcause", csr_wdata, 2); cyc_end();

    // Interrupt raised during W_MEPC waits for IDLE
    valid_wb = 1; illegal_inst = 1; mstatus = 32'h8;
    cycle();
    illegal_inst = 0; interrupt = 1;
    cyc_begin(); check("late_irq_mepc_redir", redirect, 0); cyc_end();
    cyc_begin(); check("late_irq_mcause_redir", redirect, 0); check("late_irq_mcause", csr_wdata, 2); cyc_end();
    cyc_begin(); check("late_irq_taken", redirect, 1); cyc_end();
    quiet();
    cycle();
    cyc_begin(); check("late_irq_cause", csr_wdata, IRQ); cyc_end();

    // rst in W_MEPC aborts the sequence
    valid_wb = 1; illegal_inst = 1;
    cycle();
    quiet(); rst = 1;
    cyc_begin(); check("abort_w", csr_w, 0); check("abort_busy", busy, 0); cyc_end();
    rst = 0;
    cyc_begin(); check("abort_no_mcause", csr_w, 0); check("abort_idle_busy", busy, 0); cyc_end();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 249) == 0);
      valid_wb     = ($urandom_range(0, 3) != 0);
      illegal_inst = ($urandom_range(0, 11) == 0);
      ecall_m      = ($urandom_range(0, 11) == 0);
      l_fault      = ($urandom_range(0, 11) == 0);
      s_fault      = ($urandom_range(0, 11) == 0);
      interrupt    = ($urandom_range(0, 4) == 0);
      mret         = ($urandom_range(0, 7) == 0);
      inst_wb      = $urandom; addr_wb = $urandom;
      epc_cur      = $urandom; epc_next = $urandom;
      csr_rw_in    = $urandom_range(0, 1);
      csr_wsc_in   = 2'($urandom_range(0, 3));
      csr_waddr_in = 12'($urandom);
      csr_wdata_in = $urandom;
      mstatus      = $urandom; mepc = $urandom; mtvec = $urandom;
      cycle();
    end
    rst = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
